// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR filter: control states and default sizing.
package fir_filter_pkg;

  localparam int unsigned DEF_TAPS   = 5;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_filter_datapath.sv
// Sample history shift register and unsigned multiply-accumulate for the FIR filter.
module fir_datapath
  import fir_filter_pkg::*;
#(
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [TAPS-1:0][DATA_W-1:0]   coeffs,
  output logic [OUT_W-1:0]              sum
);

  localparam int unsigned IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic [TAPS-2:0][DATA_W-1:0] hist;
  logic [TAPS-1:0][DATA_W-1:0] taps;
  logic [2*DATA_W-1:0]         prod;

  // The sum is formed over the history as it will look after the shift,
  // so the registered result already includes the incoming sample.
  assign taps = {hist, data_in};

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist <= '0;
    end else if (shift) begin
      hist <= taps[TAPS-2:0];
    end
  end

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      prod = {{DATA_W{1'b0}}, taps[k[IDX_W-1:0]]} * {{DATA_W{1'b0}}, coeffs[k[IDX_W-1:0]]};
      sum  = sum + OUT_W'(prod);
    end
  end

endmodule

// File: rtl/fir_filter.sv
// FIR filter top: coefficient-load / run / error control FSM around fir_datapath.
module fir_filter
  import fir_filter_pkg::*;
#(
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              coef_enable,
  input  logic              sample_enable,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_enable,
  output logic              error
);

  localparam int unsigned COUNT_W = $clog2(TAPS + 1);
  localparam int unsigned IDX_W   = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                      state;
  logic [COUNT_W-1:0]          count;
  logic [TAPS-1:0][DATA_W-1:0] coeffs;
  logic [OUT_W-1:0]            sum;
  logic                        accept;

  assign accept = (state == RUN) && !coef_enable && sample_enable;

  fir_datapath #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .shift   (accept),
    .data_in (data_in),
    .coeffs  (coeffs),
    .sum     (sum)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      coeffs     <= '0;
      data_out   <= '0;
      out_enable <= 1'b0;
      error      <= 1'b0;
    end else begin
      out_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_enable) begin
            coeffs[0] <= data_in;
            count     <= COUNT_W'(1);
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (coef_enable) begin
            coeffs[count[IDX_W-1:0]] <= data_in;
            count <= count + COUNT_W'(1);
            if (count == COUNT_W'(TAPS - 1)) begin
              state <= RUN;
            end
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        RUN: begin
          if (coef_enable) begin
            state <= ERR;
            error <= 1'b1;
          end else if (sample_enable) begin
            data_out   <= sum;
            out_enable <= 1'b1;
          end
        end
        ERR: begin
          error <= 1'b1;
        end
        default: begin
          state <= ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter with hand-computed expected outputs.
module tb_fir_filter;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic [15:0] data_out;
  logic        out_enable;
  logic        error;

  int unsigned n_checks;
  int unsigned n_pass;

  fir_filter #(
    .TAPS   (5),
    .DATA_W (8),
    .OUT_W  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .coef_enable   (coef_enable),
    .sample_enable (sample_enable),
    .data_out      (data_out),
    .out_enable    (out_enable),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle past it for sampling.
  task automatic step(input logic ce, input logic se, input logic [7:0] d);
    coef_enable   = ce;
    sample_enable = se;
    data_in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 1'b0, 8'd0);
    reset = 1'b1;
  endtask

  task automatic load_coeffs(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                             input logic [7:0] c3, input logic [7:0] c4);
    step(1'b1, 1'b0, c0);
    step(1'b1, 1'b0, c1);
    step(1'b1, 1'b0, c2);
    step(1'b1, 1'b0, c3);
    step(1'b1, 1'b0, c4);
    step(1'b0, 1'b0, 8'd0);
  endtask

  logic [15:0] step_exp    [5] = '{16'd4, 16'd9, 16'd15, 16'd22, 16'd30};
  logic [15:0] impulse_exp [5] = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
  logic [7:0]  impulse_in  [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [15:0] wrap_exp    [5] = '{16'd65025, 16'd64514, 16'd64003, 16'd63492, 16'd62981};

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    data_in       = '0;
    coef_enable   = 1'b0;
    sample_enable = 1'b0;

    do_reset();
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_out_enable", 32'(out_enable), 32'd0);
    check("reset_error", 32'(error), 32'd0);

    step(1'b0, 1'b1, 8'd9);
    check("idle_ignores_sample_oe", 32'(out_enable), 32'd0);
    check("idle_ignores_sample_do", 32'(data_out), 32'd0);

    // Step response
    load_coeffs(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    check("load_no_error", 32'(error), 32'd0);
    check("idle_cycle_oe", 32'(out_enable), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'd1);
      check($sformatf("step_do%0d", i), 32'(data_out), 32'(step_exp[i]));
      check($sformatf("step_oe%0d", i), 32'(out_enable), 32'd1);
    end
    step(1'b0, 1'b0, 8'd77);
    check("hold_oe", 32'(out_enable), 32'd0);
    check("hold_do", 32'(data_out), 32'd30);

    // Impulse response
    do_reset();
    load_coeffs(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, impulse_in[i]);
      check($sformatf("impulse_do%0d", i), 32'(data_out), 32'(impulse_exp[i]));
    end

    // Protocol error in RUN
    do_reset();
    load_coeffs(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    step(1'b0, 1'b1, 8'd1);
    check("perr_do0", 32'(data_out), 32'd4);
    step(1'b0, 1'b1, 8'd1);
    check("perr_do1", 32'(data_out), 32'd9);
    step(1'b1, 1'b1, 8'd1);
    check("perr_error", 32'(error), 32'd1);
    check("perr_oe", 32'(out_enable), 32'd0);
    check("perr_do_held", 32'(data_out), 32'd9);
    step(1'b0, 1'b1, 8'd1);
    check("perr_later_oe", 32'(out_enable), 32'd0);
    check("perr_later_do", 32'(data_out), 32'd9);
    check("perr_sticky", 32'(error), 32'd1);

    // Reset recovery out of ERR, then fresh load
    do_reset();
    check("recover_error", 32'(error), 32'd0);
    check("recover_do", 32'(data_out), 32'd0);
    check("recover_oe", 32'(out_enable), 32'd0);
    load_coeffs(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'd1);
      check($sformatf("recover_do%0d", i), 32'(data_out), 32'(step_exp[i]));
    end

    // Short load
    do_reset();
    step(1'b1, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd5);
    step(1'b1, 1'b0, 8'd6);
    check("short_before", 32'(error), 32'd0);
    step(1'b0, 1'b0, 8'd0);
    check("short_error", 32'(error), 32'd1);
    step(1'b0, 1'b1, 8'd1);
    check("short_no_accept", 32'(out_enable), 32'd0);

    // Reset mid-load abandons the partial load
    do_reset();
    step(1'b1, 1'b0, 8'd99);
    step(1'b1, 1'b0, 8'd99);
    do_reset();
    load_coeffs(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    step(1'b0, 1'b1, 8'd1);
    check("midload_reset_do", 32'(data_out), 32'd4);

    // Overflow wrap
    do_reset();
    load_coeffs(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'd255);
      check($sformatf("wrap_do%0d", i), 32'(data_out), 32'(wrap_exp[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 Parameter TAPS, default 5: number of filter taps and coefficients.
REQ-002 Parameter DATA_W, default 8: width of data_in, each sample and each coefficient.
REQ-003 Parameter OUT_W, default 16: width of data_out.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Port list, one port per line:
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-low; 0 = reset, 1 = run.
- data_in  input  DATA_W: coefficient value during load, sample value during run; unsigned.
- coef_enable  input  1: request to load the coefficient on data_in.
- sample_enable  input  1: request to accept the sample on data_in.
- data_out  output  OUT_W: registered filter result.
- out_enable  output  1: one-cycle valid strobe for data_out.
- error  output  1: sticky protocol-error flag.

Function
REQ-006 The block SHALL have four states: IDLE, LOAD, RUN, ERR.
REQ-007 IDLE with coef_enable=1 SHALL write coeff[0]=data_in, set count=1 and go to LOAD; otherwise it SHALL stay in IDLE, and sample_enable is ignored.
REQ-008 LOAD with coef_enable=1 SHALL write coeff[count]=data_in and increment count.
REQ-009 On the write that makes count=TAPS, the block SHALL go to RUN.
REQ-010 LOAD with coef_enable=0 before all TAPS coefficients are written SHALL go to ERR.
REQ-011 After entry to RUN, coef_enable SHALL be held 0 for at least one clock; that idle cycle is legal.
REQ-012 RUN with coef_enable=0 and sample_enable=1 SHALL shift data_in into the sample history, with x[0] as the newest sample.
REQ-013 On the same edge as REQ-012, the block SHALL register data_out = sum over k=0..TAPS-1 of coeff[k]*x[k], including the new sample, and set out_enable=1.
REQ-014 Latency SHALL be one cycle: the result is visible immediately after the accepting edge.
REQ-015 out_enable SHALL be 1 only in the cycle following an accepted sample.
REQ-016 RUN with sample_enable=0 SHALL hold data_out and drive out_enable=0.
REQ-017 RUN with coef_enable=1 SHALL go to ERR, regardless of sample_enable; the sample SHALL NOT be accepted and out_enable=0.
REQ-018 ERR SHALL drive error=1 and out_enable=0, hold data_out, and leave only on reset.
REQ-019 Arithmetic SHALL be unsigned: products are 2*DATA_W bits, and the sum is truncated modulo 2^OUT_W (wrap, no saturation).
REQ-020 Sample history slots not yet written SHALL contribute 0.

Reset
REQ-021 On a clock edge with reset=0, the block SHALL set state=IDLE, count=0, all coefficients and samples=0, data_out=0, out_enable=0 and error=0.
REQ-022 Reset SHALL take priority over all other inputs in every state, including mid-LOAD and ERR.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, LOAD, RUN, ERR) and the default constants TAPS=5, DATA_W=8, OUT_W=16.
REQ-024 The block SHALL consist of a top-level control FSM plus one sub-module, fir_datapath.
REQ-025 fir_datapath SHALL hold the sample shift register and the multiply-accumulate, and expose an internal sum.

Verification
REQ-026 Coefficient load and step response: load coeffs 4,5,6,7,8, wait one idle cycle, then apply five samples of 1 -> data_out 4, 9, 15, 22, 30, with out_enable=1 on each.
REQ-027 Impulse response: same coeffs, samples 1,0,0,0,0 -> data_out 4, 5, 6, 7, 8.
REQ-028 Protocol error in RUN: same coeffs, samples 1,1, then coef_enable=1 with sample_enable=1 -> outputs 4, 9, then error=1, out_enable=0, data_out held at 9; later samples ignored.
REQ-029 Short load: coef_enable drops after 3 coefficients -> error=1 next cycle.
REQ-030 Overflow wrap: all coeffs 255, five samples of 255 -> final data_out = 62981 (325125 mod 65536).
REQ-031 Reset recovery: reset=0 for one edge while in ERR -> error=0, data_out=0, state IDLE; a fresh load then works per REQ-026.
